regfile_mp_sb: RTL and testbench

//  Parametrised multi-port integer register file with a per-register busy scoreboard.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/rf_read_port.sv | 40 ++++
 rtl/regfile_mp_sb.sv | 91 +++++++++
 tb/tb_regfile_mp_sb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [XLEN_DEF-1:0] word_t;
  typedef logic [AW_DEF-1:0]   reg_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array/busy lookup with optional same-cycle write forwarding.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NWR      = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned AW       = $clog2(NREGS)
) (
  input  logic [NREGS-1:0][XLEN-1:0] regs_i,
  input  logic [NREGS-1:0]           busy_i,
  input  logic [AW-1:0]              rd_addr_i,
  input  logic [NWR-1:0]             wr_en_i,
  input  logic [NWR*AW-1:0]          wr_addr_i,
  input  logic [NWR*XLEN-1:0]        wr_data_i,
  output logic [XLEN-1:0]            rd_data_o,
  output logic                       rd_busy_o
);

  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
    rd_busy_o = busy_i[rd_addr_i];
    // Ascending scan so the highest-numbered matching write port wins.
    if (BYPASS != 0) begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] == rd_addr_i)) begin
          rd_data_o = wr_data_i[k*XLEN +: XLEN];
          rd_busy_o = 1'b0;
        end
      end
    end
    if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with per-register busy scoreboard for RAW hazard detection.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 flush,
  output logic                 busy_any
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;

  // Later ports overwrite earlier ones, giving highest-k priority on address collisions.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k] && !((ZERO_REG != 0) && (wr_addr[k*AW +: AW] == '0))) begin
        regs_d[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
      end
    end
  end

  // Applied lowest priority first: writeback clear, then issue mark, then flush.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k]) begin
        busy_d[wr_addr[k*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en) begin
      busy_d[iss_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_any = |busy_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    rf_read_port #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .AW       (AW)
    ) u_rd (
      .regs_i    (regs_q),
      .busy_i    (busy_q),
      .rd_addr_i (rd_addr[i*AW +: AW]),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_data_o (rd_data[i*XLEN +: XLEN]),
      .rd_busy_o (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench: a bypassing and a non-bypassing instance share one stimulus stream.
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  localparam int unsigned AW  = AW_DEF;
  localparam int unsigned XL  = XLEN_DEF;
  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XL-1:0] rd_data, nb_rd_data;
  logic [NRD-1:0]    rd_busy, nb_rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*XL-1:0] wr_data;
  logic              iss_en;
  reg_addr_t         iss_addr;
  logic              flush;
  logic              busy_any, nb_busy_any;

  always #5 clk = ~clk;

  regfile_mp_sb #(.NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .busy_any(busy_any)
  );

  regfile_mp_sb #(.NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .busy_any(nb_busy_any)
  );

  typedef enum int {ObsRd0, ObsRd1, ObsBusy0, ObsBusy1, ObsAny, ObsNbRd0, ObsNbRd1,
                    ObsNbBusy0} obs_e;
  typedef struct {
    string tag;
    obs_e  sel;
    word_t exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic word_t observe(obs_e sel);
    case (sel)
      ObsRd0:     return rd_data[0 +: XL];
      ObsRd1:     return rd_data[XL +: XL];
      ObsBusy0:   return word_t'(rd_busy[0]);
      ObsBusy1:   return word_t'(rd_busy[1]);
      ObsAny:     return word_t'(busy_any);
      ObsNbRd0:   return nb_rd_data[0 +: XL];
      ObsNbRd1:   return nb_rd_data[XL +: XL];
      ObsNbBusy0: return word_t'(nb_rd_busy[0]);
      default:    return 'x;
    endcase
  endfunction

  task automatic check_eq(input string tag, input word_t obs, input word_t exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input obs_e sel, input word_t exp);
    sb_entry_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Let combinational outputs settle, then drain the scoreboard.
  task automatic settle_check();
    sb_entry_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1);
    rd_addr = {a1, a0};
  endtask

  task automatic set_wr(input logic [1:0] en, input reg_addr_t a0, input word_t d0,
                        input reg_addr_t a1, input word_t d1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  task automatic issue(input reg_addr_t a);
    iss_en   = 1'b1;
    iss_addr = a;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    step();
    step();
    set_rd(5'd1, 5'd31);
    expect_out("rst_rd0", ObsRd0, '0);
    expect_out("rst_rd1", ObsRd1, '0);
    expect_out("rst_busy0", ObsBusy0, '0);
    expect_out("rst_any", ObsAny, '0);
    settle_check();
    rst_n = 1'b1;

    // 1: fill, mark one busy, then async reset between edges
    for (int i = 1; i < 32; i++) begin
      step();
      set_wr(2'b01, reg_addr_t'(i), 32'hA5A5_0000 + word_t'(i), '0, '0);
    end
    step();
    idle();
    issue(5'd1);
    step();
    idle();
    expect_out("fill_x1", ObsRd0, 32'hA5A5_0001);
    expect_out("fill_x31", ObsRd1, 32'hA5A5_001F);
    expect_out("fill_busy_x1", ObsBusy0, 32'd1);
    expect_out("fill_any", ObsAny, 32'd1);
    settle_check();
    rst_n = 1'b0;
    expect_out("midrst_rd0", ObsRd0, '0);
    expect_out("midrst_rd1", ObsRd1, '0);
    expect_out("midrst_any", ObsAny, '0);
    settle_check();
    rst_n = 1'b1;

    // 2: x0 ignores writes and issue marks
    step();
    set_rd(5'd0, 5'd0);
    set_wr(2'b01, 5'd0, 32'hDEAD_BEEF, '0, '0);
    issue(5'd0);
    expect_out("x0_byp", ObsRd0, '0);
    expect_out("x0_nobyp", ObsNbRd0, '0);
    settle_check();
    step();
    idle();
    expect_out("x0_after", ObsRd1, '0);
    expect_out("x0_busy", ObsBusy0, '0);
    expect_out("x0_any", ObsAny, '0);
    settle_check();

    // 3: same-cycle bypass vs. registered-only read
    set_rd(5'd5, 5'd5);
    set_wr(2'b01, 5'd5, 32'h1234_5678, '0, '0);
    expect_out("byp_rd0", ObsRd0, 32'h1234_5678);
    expect_out("byp_rd1", ObsRd1, 32'h1234_5678);
    expect_out("nobyp_old0", ObsNbRd0, '0);
    expect_out("nobyp_old1", ObsNbRd1, '0);
    settle_check();
    step();
    idle();
    expect_out("nobyp_new", ObsNbRd0, 32'h1234_5678);
    settle_check();

    // 4: both write ports hit x7, port 1 wins
    set_rd(5'd7, 5'd5);
    set_wr(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
    expect_out("dual_byp", ObsRd0, 32'h22);
    expect_out("dual_nobyp", ObsNbRd0, '0);
    settle_check();
    step();
    idle();
    expect_out("dual_commit", ObsRd0, 32'h22);
    expect_out("dual_commit_nb", ObsNbRd0, 32'h22);
    expect_out("dual_other", ObsRd1, 32'h1234_5678);
    settle_check();

    // 5: scoreboard mark, mark-beats-clear, later clear
    set_rd(5'd3, 5'd7);
    issue(5'd3);
    expect_out("iss_not_fwd", ObsBusy0, '0);
    settle_check();
    step();
    idle();
    expect_out("iss_busy", ObsBusy0, 32'd1);
    expect_out("iss_any", ObsAny, 32'd1);
    expect_out("iss_other", ObsBusy1, '0);
    settle_check();
    issue(5'd3);
    set_wr(2'b01, 5'd3, 32'h33, '0, '0);
    expect_out("issclr_nb_busy", ObsNbBusy0, 32'd1);
    settle_check();
    step();
    idle();
    expect_out("issclr_stays", ObsBusy0, 32'd1);
    expect_out("issclr_data", ObsRd0, 32'h33);
    settle_check();
    set_wr(2'b01, 5'd3, 32'h44, '0, '0);
    expect_out("wb_byp_busy", ObsBusy0, '0);
    expect_out("wb_byp_data", ObsRd0, 32'h44);
    expect_out("wb_nb_busy", ObsNbBusy0, 32'd1);
    settle_check();
    step();
    idle();
    expect_out("wb_cleared", ObsBusy0, '0);
    expect_out("wb_any", ObsAny, '0);
    settle_check();

    // 6: flush clears everything and drops the same-cycle issue
    issue(5'd2);
    step();
    issue(5'd4);
    step();
    issue(5'd9);
    step();
    idle();
    set_rd(5'd2, 5'd4);
    expect_out("pre_fl_x2", ObsBusy0, 32'd1);
    expect_out("pre_fl_x4", ObsBusy1, 32'd1);
    settle_check();
    flush = 1'b1;
    issue(5'd6);
    step();
    idle();
    set_rd(5'd6, 5'd9);
    expect_out("fl_x6", ObsBusy0, '0);
    expect_out("fl_x9", ObsBusy1, '0);
    expect_out("fl_any", ObsAny, '0);
    settle_check();
    set_rd(5'd2, 5'd4);
    expect_out("fl_x2", ObsBusy0, '0);
    expect_out("fl_x4", ObsBusy1, '0);
    settle_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
